// File: rtl/data_bus_pkg.sv
// Shared definitions for the data bus bridge.
//   - core access width encodings (WIDTH_BYTE/HALF/WORD/NONE)
//   - bridge FSM state encodings
//   - byte-enable base masks and read masks per access width
package data_bus_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2,
    WIDTH_NONE = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unshifted lane mask for an access of the given width.
  function automatic logic [3:0] base_mask(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: base_mask = BE_BYTE;
      WIDTH_HALF: base_mask = BE_HALF;
      WIDTH_WORD: base_mask = BE_WORD;
      default:    base_mask = 4'b0000;
    endcase
  endfunction

  // Zero-extension mask applied to right-justified load data.
  function automatic logic [31:0] read_mask(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: read_mask = 32'h0000_00FF;
      WIDTH_HALF: read_mask = 32'h0000_FFFF;
      default:    read_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_bridge_if.sv
// Word-addressed memory bus between the bridge (master) and memory (slave).
//   mem_req/mem_ack : request held until acknowledged; ack may come in the
//                     same cycle as req
//   mem_we          : 1 = write
//   mem_addr        : word address (ADDR_WIDTH-2 bits)
//   mem_be          : byte enables, bit i = byte lane i
//   mem_wdata       : lane-aligned write data
//   mem_rdata       : read data, valid with mem_ack
interface data_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_lane_align.sv
// Combinational byte-lane steering for the data bus bridge.
// Inputs : offset (address[1:0]), width (access width code), wdata (core store
//          data), rdata_pair ({second word, first word} of read data).
// Outputs: be_lo/be_hi (lanes in the first/second word), wdata_lo/wdata_hi
//          (lane-aligned store data per word), rdata_ext (right-justified,
//          zero-extended load data), split_need (access crosses a word).
// The lo/hi halves are produced together so one instance serves both
// transactions of a split access.
module data_lane_align
  import data_bus_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata_pair,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata_ext,
  output logic        split_need
);
  logic [4:0]  shamt;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;

  always_comb begin
    shamt   = {offset, 3'b000};
    be_wide = {4'b0000, base_mask(width)} << offset;
    // A byte store drives its byte on every lane; the enables pick the lane.
    if (width == WIDTH_BYTE) wd_wide = {32'h0, {4{wdata[7:0]}}};
    else                     wd_wide = {32'h0, wdata} << shamt;
    be_lo      = be_wide[3:0];
    be_hi      = be_wide[7:4];
    wdata_lo   = wd_wide[31:0];
    wdata_hi   = wd_wide[63:32];
    split_need = |be_wide[7:4];
    rdata_ext  = 32'(rdata_pair >> shamt) & read_mask(width);
  end
endmodule

// File: rtl/data_bus_bridge.sv
// Data bus bridge: turns the core's single-cycle combinational data access
// into a registered, handshaked, word-aligned memory transaction with byte
// enables, stalling the core with core_wait until the access completes.
// Ports: clock, reset_n (async, active-low); core_address/core_width/
//        core_wdata/core_read/core_write in; core_rdata (zero-extended),
//        core_wait, misaligned and bus_error (one-cycle pulses) out;
//        mem : data_bus_bridge_if.master memory bus.
// Build option: MISALIGNED_SPLIT_EN - when defined, misaligned accesses are
//        split into two word transactions; otherwise they are rejected with
//        a misaligned pulse and no memory transaction.
module data_bus_bridge
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [1:0]            core_width,
  input  logic [31:0]           core_wdata,
  input  logic                  core_read,
  input  logic                  core_write,
  output logic [31:0]           core_rdata,
  output logic                  core_wait,
  output logic                  misaligned,
  output logic                  bus_error,
  data_bus_bridge_if.master     mem
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                state;
  logic                  req_q, we_q, split_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [3:0]            be_q, be_hi_q;
  logic [31:0]           wd_q, wd_hi_q, rd_lo_q;
  logic [1:0]            off_q, width_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  core_request;
  logic [1:0]            al_off, al_width;
  logic [63:0]           al_rpair;
  logic [3:0]            be_lo, be_hi;
  logic [31:0]           wd_lo, wd_hi, rd_ext;
  logic                  split_need;

  assign core_request = (core_read | core_write) && (core_width != WIDTH_NONE);

  // The aligner sees the live core access while idle and the registered
  // access afterwards, where it extracts read data.
  always_comb begin
    al_off   = (state == IDLE) ? core_address[1:0] : off_q;
    al_width = (state == IDLE) ? core_width        : width_q;
    al_rpair = (state == REQ1) ? {mem.mem_rdata, rd_lo_q} : {32'h0, mem.mem_rdata};
  end

  data_lane_align u_align (
    .offset     (al_off),
    .width      (al_width),
    .wdata      (core_wdata),
    .rdata_pair (al_rpair),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .wdata_lo   (wd_lo),
    .wdata_hi   (wd_hi),
    .rdata_ext  (rd_ext),
    .split_need (split_need)
  );

  always_comb begin
    core_wait = 1'b0;
    case (state)
      IDLE:       core_wait = core_request;
      REQ0, REQ1: core_wait = 1'b1;
      default:    core_wait = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      be_hi_q    <= 4'b0000;
      wd_q       <= 32'h0;
      wd_hi_q    <= 32'h0;
      rd_lo_q    <= 32'h0;
      off_q      <= 2'b00;
      width_q    <= 2'b00;
      cnt_q      <= '0;
      core_rdata <= 32'h0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (core_request) begin
            off_q   <= core_address[1:0];
            width_q <= core_width;
            we_q    <= core_write;
            addr_q  <= core_address[ADDR_WIDTH-1:2];
            be_q    <= be_lo;
            wd_q    <= wd_lo;
            be_hi_q <= be_hi;
            wd_hi_q <= wd_hi;
            cnt_q   <= '0;
            split_q <= 1'b0;
            if (split_need) begin
`ifdef MISALIGNED_SPLIT_EN
              split_q <= 1'b1;
              req_q   <= 1'b1;
              state   <= REQ0;
`else
              misaligned <= 1'b1;
              core_rdata <= 32'h0;
              state      <= DONE;
`endif
            end else begin
              req_q <= 1'b1;
              state <= REQ0;
            end
          end
        end
        REQ0, REQ1: begin
          // An ack in the limit cycle takes priority over the timeout.
          if (mem.mem_ack) begin
            cnt_q <= '0;
            if (state == REQ0 && split_q) begin
              rd_lo_q <= mem.mem_rdata;
              addr_q  <= addr_q + (ADDR_WIDTH-2)'(1);
              be_q    <= be_hi_q;
              wd_q    <= wd_hi_q;
              state   <= REQ1;
            end else begin
              req_q      <= 1'b0;
              core_rdata <= rd_ext;
              state      <= DONE;
            end
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
            req_q      <= 1'b0;
            bus_error  <= 1'b1;
            core_rdata <= 32'h0;
            cnt_q      <= '0;
            state      <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // The core retires here while its request is still visible; going
        // straight back to IDLE keeps that request from being re-issued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wd_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Testbench for data_bus_bridge: table of aligned accesses with same-cycle
// ack, plus hand-written sequences for no-access width, misaligned handling,
// ack timeout and reset in the middle of a transaction.
module tb_data_bus_bridge;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] core_address;
  logic [1:0]  core_width;
  logic [31:0] core_wdata;
  logic        core_read, core_write;
  logic [31:0] core_rdata;
  logic        core_wait, misaligned, bus_error;
  logic        ack_en;
  logic [31:0] rd_even, rd_odd;

  data_bus_bridge_if #(.ADDR_WIDTH(32)) mif ();

  assign mif.mem_ack   = mif.mem_req & ack_en;
  assign mif.mem_rdata = mif.mem_addr[0] ? rd_odd : rd_even;

  data_bus_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .core_address (core_address),
    .core_width   (core_width),
    .core_wdata   (core_wdata),
    .core_read    (core_read),
    .core_write   (core_write),
    .core_rdata   (core_rdata),
    .core_wait    (core_wait),
    .misaligned   (misaligned),
    .bus_error    (bus_error),
    .mem          (mif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    else n_pass++;
  endfunction

  function automatic logic [31:0] lane_mask(logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{be[i]}};
  endfunction

  // Observations of the most recent access.
  int          n_wait, n_req, n_beat, n_mis, n_berr;
  logic [29:0] b_addr [2];
  logic [3:0]  b_be   [2];
  logic        b_we   [2];
  logic [31:0] b_wd   [2];
  logic [31:0] got_rd;

  // Called at posedge+1 with the bridge idle; returns at posedge+1 idle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    bit done = 1'b0;
    core_read = rd; core_write = wr; core_width = w;
    core_address = a; core_wdata = d;
    n_wait = 0; n_req = 0; n_beat = 0; n_mis = 0; n_berr = 0; got_rd = 'x;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (core_wait) n_wait++;
      if (mif.mem_req) n_req++;
      if (mif.mem_req && mif.mem_ack && n_beat < 2) begin
        b_addr[n_beat] = mif.mem_addr;
        b_be[n_beat]   = mif.mem_be;
        b_we[n_beat]   = mif.mem_we;
        b_wd[n_beat]   = mif.mem_wdata;
        n_beat++;
      end
      if (misaligned) n_mis++;
      if (bus_error) n_berr++;
      if (!core_wait) begin
        got_rd = core_rdata;
        done   = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wait_bound: core_wait still high after 20 cycles, expected release");
    end
    @(posedge clock); #1;
    check("no_reissue", {31'h0, mif.mem_req}, 32'h0);
    core_read = 1'b0; core_write = 1'b0; core_width = 2'd3;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] mrd;
    logic [29:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  initial begin
    vt[0] = '{1'b1, 1'b0, 2'd2, 32'h100, 32'h0,        32'hDEADBEEF, 30'h40, 4'b1111, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b1, 2'd0, 32'h203, 32'h000000A5, 32'h0,        30'h80, 4'b1000, 32'hA5000000, 32'h0};
    vt[2] = '{1'b1, 1'b0, 2'd1, 32'h202, 32'h0,        32'h12345678, 30'h80, 4'b1100, 32'h0,        32'h00001234};
    vt[3] = '{1'b1, 1'b0, 2'd0, 32'h101, 32'h0,        32'h11223344, 30'h40, 4'b0010, 32'h0,        32'h00000033};
    vt[4] = '{1'b0, 1'b1, 2'd1, 32'h102, 32'h0000BEEF, 32'h0,        30'h40, 4'b1100, 32'hBEEF0000, 32'h0};
    vt[5] = '{1'b0, 1'b1, 2'd2, 32'h0FC, 32'hCAFEF00D, 32'h0,        30'h3F, 4'b1111, 32'hCAFEF00D, 32'h0};
    vt[6] = '{1'b1, 1'b1, 2'd1, 32'h000, 32'h12345678, 32'h0,        30'h00, 4'b0011, 32'h00005678, 32'h0};
    vt[7] = '{1'b1, 1'b0, 2'd1, 32'h001, 32'h0,        32'hAABBCCDD, 30'h00, 4'b0110, 32'h0,        32'h0000BBCC};
    vt[8] = '{1'b1, 1'b0, 2'd0, 32'h3FF, 32'h0,        32'h80FF0000, 30'hFF, 4'b1000, 32'h0,        32'h00000080};

    reset_n = 1'b0; ack_en = 1'b1; rd_even = 32'h0; rd_odd = 32'h0;
    core_read = 1'b0; core_write = 1'b0; core_width = 2'd3;
    core_address = 32'h0; core_wdata = 32'h0;

    // Reset state
    #12;
    check("rst_mem_req",    {31'h0, mif.mem_req},   32'h0);
    check("rst_mem_we",     {31'h0, mif.mem_we},    32'h0);
    check("rst_mem_be",     {28'h0, mif.mem_be},    32'h0);
    check("rst_mem_addr",   {2'b00, mif.mem_addr},  32'h0);
    check("rst_mem_wdata",  mif.mem_wdata,          32'h0);
    check("rst_core_rdata", core_rdata,             32'h0);
    check("rst_core_wait",  {31'h0, core_wait},     32'h0);
    check("rst_pulses",     {30'h0, misaligned, bus_error}, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Aligned accesses, ack in the same cycle as req
    for (int i = 0; i < NV; i++) begin
      rd_even = vt[i].mrd; rd_odd = vt[i].mrd;
      access(vt[i].rd, vt[i].wr, vt[i].w, vt[i].a, vt[i].d);
      check($sformatf("v%0d_wait_cycles", i), n_wait,            2);
      check($sformatf("v%0d_beats", i),       n_beat,            1);
      check($sformatf("v%0d_addr", i),        {2'b00, b_addr[0]}, {2'b00, vt[i].e_addr});
      check($sformatf("v%0d_be", i),          {28'h0, b_be[0]},   {28'h0, vt[i].e_be});
      check($sformatf("v%0d_we", i),          {31'h0, b_we[0]},   {31'h0, vt[i].wr});
      if (vt[i].wr)
        check($sformatf("v%0d_wdata", i), b_wd[0] & lane_mask(vt[i].e_be), vt[i].e_wd);
      else
        check($sformatf("v%0d_rdata", i), got_rd, vt[i].e_rd);
    end

    // Width code 3 is not an access
    core_read = 1'b1; core_width = 2'd3; core_address = 32'h100;
    #1 check("none_wait", {31'h0, core_wait}, 32'h0);
    @(posedge clock); #1;
    check("none_req", {31'h0, mif.mem_req}, 32'h0);
    core_read = 1'b0;
    @(posedge clock); #1;

    // Misaligned word load at 0x101 and half store at 0x003
    rd_even = 32'h33221100; rd_odd = 32'h77665544;
    access(1'b1, 1'b0, 2'd2, 32'h101, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
    check("split_wait",  n_wait, 3);
    check("split_beats", n_beat, 2);
    check("split_be0",   {28'h0, b_be[0]}, 32'hE);
    check("split_addr0", {2'b00, b_addr[0]}, 32'h40);
    check("split_be1",   {28'h0, b_be[1]}, 32'h1);
    check("split_addr1", {2'b00, b_addr[1]}, 32'h41);
    check("split_rdata", got_rd, 32'h44332211);
    check("split_mis",   n_mis, 0);
    access(1'b0, 1'b1, 2'd1, 32'h003, 32'h0000BEEF);
    check("splitst_beats", n_beat, 2);
    check("splitst_lane0", b_wd[0] & 32'hFF000000, 32'hEF000000);
    check("splitst_lane1", b_wd[1] & 32'h000000FF, 32'h000000BE);
`else
    check("mis_req",   n_req,  0);
    check("mis_pulse", n_mis,  1);
    check("mis_wait",  n_wait, 1);
    check("mis_rdata", got_rd, 32'h0);
    access(1'b0, 1'b1, 2'd1, 32'h003, 32'h0000BEEF);
    check("mis_st_req",   n_req, 0);
    check("mis_st_pulse", n_mis, 1);
`endif

    // Ack never arrives: abort after 4 request cycles
    rd_even = 32'h12345678; rd_odd = 32'h12345678;
    access(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
    check("pre_to_rdata", got_rd, 32'h78);
    ack_en = 1'b0;
    access(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    check("to_req_cycles", n_req,  4);
    check("to_bus_error",  n_berr, 1);
    check("to_rdata",      got_rd, 32'h0);
    check("to_wait",       n_wait, 5);

    // Reset while the request is outstanding
    core_read = 1'b1; core_width = 2'd2; core_address = 32'h100;
    for (int c = 0; c < 5 && !mif.mem_req; c++) @(negedge clock);
    check("rst_mid_req_seen", {31'h0, mif.mem_req}, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_req_drop", {31'h0, mif.mem_req}, 32'h0);
    core_read = 1'b0; core_width = 2'd3;
    #1 check("rst_mid_wait", {31'h0, core_wait}, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1; ack_en = 1'b1;
    @(posedge clock); #1;
    rd_even = 32'h0BADF00D; rd_odd = 32'h0BADF00D;
    access(1'b1, 1'b0, 2'd2, 32'h200, 32'h0);
    check("post_rst_wait",  n_wait, 2);
    check("post_rst_addr",  {2'b00, b_addr[0]}, 32'h80);
    check("post_rst_be",    {28'h0, b_be[0]}, 32'hF);
    check("post_rst_rdata", got_rd, 32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
